arbitro_rr_4a1_4b: RTL and testbench

- Round-robin arbiter and sequencer for the 4-to-1, 4-bit valid/data mux path.
- Four requesters present valid_inN/data_inN. The block grants at most one per cycle and pops the winner.
- Drives a registered data_out/valid_out pair, plus the 3-bit selector in the encoding the two-level 2:1 mux tree expects.
- Honours a downstream pause (almost-full) input and exposes its FSM state for verification.

---
 rtl/arbitro_rr_4a1_4b.sv | 142 ++++++++++++++
 tb/tb_arbitro_rr_4a1_4b.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_rr_4a1_4b.sv
// Round-robin 4:1 arbiter/sequencer with registered output and pause handling.
// Optional per-requester grant counters: define ARB_GRANT_COUNT_EN.
module arbitro_rr_4a1_4b #(
    parameter int DATA_WIDTH = 4
`ifdef ARB_GRANT_COUNT_EN
    ,
    parameter int CNT_WIDTH  = 8
`endif
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  valid_in0,
    input  logic                  valid_in1,
    input  logic                  valid_in2,
    input  logic                  valid_in3,
    input  logic [DATA_WIDTH-1:0] data_in0,
    input  logic [DATA_WIDTH-1:0] data_in1,
    input  logic [DATA_WIDTH-1:0] data_in2,
    input  logic [DATA_WIDTH-1:0] data_in3,
    input  logic                  pause,
    output logic                  pop0,
    output logic                  pop1,
    output logic                  pop2,
    output logic                  pop3,
    output logic [2:0]            selector,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic [1:0]            state
`ifdef ARB_GRANT_COUNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  grant_cnt0,
    output logic [CNT_WIDTH-1:0]  grant_cnt1,
    output logic [CNT_WIDTH-1:0]  grant_cnt2,
    output logic [CNT_WIDTH-1:0]  grant_cnt3
`endif
);

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        IDLE   = 2'd1,
        ACTIVE = 2'd2,
        PAUSE  = 2'd3
    } state_t;

    state_t                  st_q;
    state_t                  st_d;
    logic [1:0]              last_q;
    logic [3:0]              valid_vec;
    logic [3:0]              pop_vec;
    logic                    any_valid;
    logic                    grant_en;
    logic                    grant;
    logic                    found;
    logic [1:0]              idx;
    logic [1:0]              win;
    logic [DATA_WIDTH-1:0]   win_data;
    logic [2:0]              win_sel;

    assign valid_vec = {valid_in3, valid_in2, valid_in1, valid_in0};
    assign any_valid = |valid_vec;
    assign state     = st_q;

    // Search starts one past the last winner and ends on it.
    always_comb begin
        win   = last_q;
        found = 1'b0;
        idx   = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_q + 2'(k);
            if (!found && valid_vec[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    assign grant_en = reset_L && !pause &&
                      (st_q == IDLE || st_q == ACTIVE);
    assign grant    = grant_en && any_valid;
    assign pop_vec  = grant ? (4'b0001 << win) : 4'b0000;

    assign pop0 = pop_vec[0];
    assign pop1 = pop_vec[1];
    assign pop2 = pop_vec[2];
    assign pop3 = pop_vec[3];

    always_comb begin
        win_data = data_in0;
        win_sel  = 3'b000;
        unique case (win)
            2'd0: begin win_data = data_in0; win_sel = 3'b000; end
            2'd1: begin win_data = data_in1; win_sel = 3'b001; end
            2'd2: begin win_data = data_in2; win_sel = 3'b100; end
            2'd3: begin win_data = data_in3; win_sel = 3'b110; end
        endcase
    end

    always_comb begin
        st_d = st_q;
        unique case (st_q)
            INIT:   st_d = IDLE;
            IDLE:   st_d = pause ? PAUSE : (any_valid ? ACTIVE : IDLE);
            ACTIVE: st_d = pause ? PAUSE : (any_valid ? ACTIVE : IDLE);
            PAUSE:  st_d = pause ? PAUSE : IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            st_q      <= INIT;
            last_q    <= 2'd3;
            data_out  <= '0;
            valid_out <= 1'b0;
            selector  <= 3'b000;
        end else begin
            st_q      <= st_d;
            valid_out <= grant;
            if (grant) begin
                last_q   <= win;
                data_out <= win_data;
                selector <= win_sel;
            end
        end
    end

`ifdef ARB_GRANT_COUNT_EN
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
            grant_cnt2 <= '0;
            grant_cnt3 <= '0;
        end else begin
            if (pop_vec[0]) grant_cnt0 <= grant_cnt0 + 1'b1;
            if (pop_vec[1]) grant_cnt1 <= grant_cnt1 + 1'b1;
            if (pop_vec[2]) grant_cnt2 <= grant_cnt2 + 1'b1;
            if (pop_vec[3]) grant_cnt3 <= grant_cnt3 + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_arbitro_rr_4a1_4b.sv
// Directed-vector bench for arbitro_rr_4a1_4b.
// Grant counter checks run when ARB_GRANT_COUNT_EN is defined.
module tb_arbitro_rr_4a1_4b;

    logic       clk = 1'b0;
    logic       reset_L;
    logic       valid_in0, valid_in1, valid_in2, valid_in3;
    logic [3:0] data_in0, data_in1, data_in2, data_in3;
    logic       pause;
    logic       pop0, pop1, pop2, pop3;
    logic [2:0] selector;
    logic [3:0] data_out;
    logic       valid_out;
    logic [1:0] state;
`ifdef ARB_GRANT_COUNT_EN
    logic [1:0] grant_cnt0, grant_cnt1, grant_cnt2, grant_cnt3;
`endif

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    arbitro_rr_4a1_4b #(
        .DATA_WIDTH(4)
`ifdef ARB_GRANT_COUNT_EN
        ,
        .CNT_WIDTH(2)
`endif
    ) dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .valid_in0 (valid_in0),
        .valid_in1 (valid_in1),
        .valid_in2 (valid_in2),
        .valid_in3 (valid_in3),
        .data_in0  (data_in0),
        .data_in1  (data_in1),
        .data_in2  (data_in2),
        .data_in3  (data_in3),
        .pause     (pause),
        .pop0      (pop0),
        .pop1      (pop1),
        .pop2      (pop2),
        .pop3      (pop3),
        .selector  (selector),
        .data_out  (data_out),
        .valid_out (valid_out),
        .state     (state)
`ifdef ARB_GRANT_COUNT_EN
        ,
        .grant_cnt0(grant_cnt0),
        .grant_cnt1(grant_cnt1),
        .grant_cnt2(grant_cnt2),
        .grant_cnt3(grant_cnt3)
`endif
    );

    wire [3:0] pops = {pop3, pop2, pop1, pop0};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_valid(input logic [3:0] v);
        {valid_in3, valid_in2, valid_in1, valid_in0} = v;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [2:0] sel_tab [4];
        sel_tab[0] = 3'b000;
        sel_tab[1] = 3'b001;
        sel_tab[2] = 3'b100;
        sel_tab[3] = 3'b110;

        data_in0 = 4'hA; data_in1 = 4'hB;
        data_in2 = 4'hC; data_in3 = 4'hD;
        pause    = 1'b0;
        reset_L  = 1'b0;
        set_valid(4'b1111);

        // reset held with requests present
        chk("rst_pop", pops, 4'b0000);
        tick;
        chk("rst_state", state, 2'd0);
        chk("rst_vout", valid_out, 1'b0);
        chk("rst_dout", data_out, 4'h0);
        chk("rst_sel", selector, 3'b000);
        reset_L = 1'b1;
        set_valid(4'b0000);
        chk("init_pop", pops, 4'b0000);
        tick;
        chk("idle_state", state, 2'd1);
        chk("idle_vout", valid_out, 1'b0);

        // full rotation
        set_valid(4'b1111);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("rot_pop%0d", i), pops, 4'b0001 << (i % 4));
            tick;
            chk($sformatf("rot_dout%0d", i), data_out, 4'hA + 4'(i % 4));
            chk($sformatf("rot_sel%0d", i), selector, sel_tab[i % 4]);
            chk($sformatf("rot_vout%0d", i), valid_out, 1'b1);
            chk($sformatf("rot_st%0d", i), state, 2'd2);
        end

        // lone requester back-to-back
        set_valid(4'b0100);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("lone_pop%0d", i), pops, 4'b0100);
            tick;
            chk($sformatf("lone_dout%0d", i), data_out, 4'hC);
            chk($sformatf("lone_vout%0d", i), valid_out, 1'b1);
            chk($sformatf("lone_sel%0d", i), selector, 3'b100);
        end
        set_valid(4'b0000);
        chk("drain_pop", pops, 4'b0000);
        tick;
        chk("drain_state", state, 2'd1);
        chk("drain_vout", valid_out, 1'b0);
        chk("drain_dout", data_out, 4'hC);
        chk("drain_sel", selector, 3'b100);

        // sparse requests: last=2 -> 3 skipped? 3 valid wins
        set_valid(4'b1010);
        chk("sparse_pop0", pops, 4'b1000);
        tick;
        chk("sparse_dout0", data_out, 4'hD);
        chk("sparse_pop1", pops, 4'b0010);
        tick;
        chk("sparse_dout1", data_out, 4'hB);
        chk("sparse_sel1", selector, 3'b001);

        // pause after grant to 1
        set_valid(4'b1111);
        pause = 1'b1;
        #1;
        chk("pause_pop", pops, 4'b0000);
        tick;
        chk("pause_state", state, 2'd3);
        chk("pause_vout", valid_out, 1'b0);
        chk("pause_dout", data_out, 4'hB);
        pause = 1'b0;
        #1;
        chk("bubble_pop", pops, 4'b0000);
        tick;
        chk("bubble_state", state, 2'd1);
        chk("bubble_vout", valid_out, 1'b0);
        chk("resume_pop", pops, 4'b0100);
        tick;
        chk("resume_dout", data_out, 4'hC);
        chk("resume_state", state, 2'd2);

        // reset during ACTIVE
        reset_L = 1'b0;
        #1;
        chk("midrst_pop", pops, 4'b0000);
        tick;
        chk("midrst_state", state, 2'd0);
        chk("midrst_dout", data_out, 4'h0);
        chk("midrst_vout", valid_out, 1'b0);
        chk("midrst_sel", selector, 3'b000);
        reset_L = 1'b1;
        #1;
        chk("postrst_init_pop", pops, 4'b0000);
        tick;
        chk("postrst_pop", pops, 4'b0001);
        tick;
        chk("postrst_dout", data_out, 4'hA);
        chk("postrst_sel", selector, 3'b000);

`ifdef ARB_GRANT_COUNT_EN
        reset_L = 1'b0;
        tick;
        chk("cnt_rst0", grant_cnt0, 2'd0);
        reset_L = 1'b1;
        set_valid(4'b0010);
        tick;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("cnt_pop%0d", i), pops, 4'b0010);
            tick;
            chk($sformatf("cnt1_%0d", i), grant_cnt1, 2'((i + 1) % 4));
            chk($sformatf("cnt0_%0d", i), grant_cnt0, 2'd0);
            chk($sformatf("cnt2_%0d", i), grant_cnt2, 2'd0);
            chk($sformatf("cnt3_%0d", i), grant_cnt3, 2'd0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
